dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-ported 16-bit `data_mem` in the MIPS datapath. It shares `data_mem` between requester 0 (CPU load/store stage) and requester 1 (debug/loader port) using a req/done handshake with round-robin fairness. It captures each winner's command, drives one memory access, and returns read data through a per-requester register.

## Interface
- `ADDR_W`, default 16: address width, passed unchanged to `data_mem`.
- `DATA_W`, default 16: data width.

Ports:
- `clk` in 1: single clock. The arbiter acts on rising edges.
- `rst` in 1: synchronous, active-high reset.
- `m0_req` / `m1_req` in 1: request. Held high until the matching `done`.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr` / `m1_addr` in ADDR_W: word address.
- `m0_wdata` / `m1_wdata` in DATA_W: write data.
- `m0_gnt` / `m1_gnt` out 1: high for the requester's ACCESS cycle.
- `m0_done` / `m1_done` out 1: one-cycle completion pulse.
- `m0_rdata` / `m1_rdata` out DATA_W: registered read result. Holds its value until the same requester completes its next read.
- `mem_addr` out ADDR_W: to `data_mem` address.
- `mem_we` out 1: to `data_mem` MemWrite.
- `mem_wdata` out DATA_W: to `data_mem` writeData.
- `mem_rdata` in DATA_W: from `data_mem` readData. This is a combinational read of `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one `req` is high, that requester wins.
  - If both are high, the requester not marked in `last` wins.
  - At the granting edge, the arbiter captures the winner's `we`, `addr` and `wdata` into `cmd_*` registers, sets `owner`, sets `last` to `owner`, and moves to ACCESS.
  - If no `req` is high, it stays in IDLE.
- ACCESS (exactly one cycle):
  - `mem_addr` = `cmd_addr`, `mem_wdata` = `cmd_wdata`, `mem_we` = `cmd_we & ~rst`.
  - The `gnt` of `owner` is high.
  - At the closing edge, `data_mem` performs the write if `cmd_we` = 1.
  - If `cmd_we` = 0, `mem_rdata` is loaded into the owner's `rdata`.
  - Next state is RESP.
- RESP (one cycle):
  - The owner's `done` = 1.
  - All `req` inputs are ignored, because the owner's `req` is still high in this cycle.
  - Next state is IDLE.
- Requester rule: the requester deasserts `req` in the cycle after `done`, or keeps it high to issue a new request. A `req` still high in IDLE is a new request with the payload present at that time.
- `req` dropped or payload changed after grant: no effect. The captured command completes and `done` still pulses.
- Writes never change any `rdata` register. The non-owner's `rdata` never changes.
- When not in ACCESS: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, both `gnt` = 0.
- Addresses pass through unchecked. Range handling belongs to `data_mem`.

## Timing
- Reset, applied at any edge with `rst` = 1:
  - state = IDLE, `owner` = 0, `last` = 1 (so requester 0 wins the first tie).
  - `cmd_*` = 0, both `rdata` = 0, all `gnt` and `done` = 0.
  - `mem_we`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-operation: `mem_we` is gated by `rst` in the same cycle, so an in-flight write never reaches memory. No `done` is issued for the aborted access.
- Latency: `req` sampled at edge N → `gnt` in cycle N+1 → `done` and valid `rdata` in cycle N+2.
- Throughput: one access per 3 cycles for a single requester.
- Under continuous contention from both requesters, grants alternate 0,1,0,1. Each requester's wait is at most 3 cycles beyond its own 3-cycle access.
- `gnt` and `done` are never high for both requesters in the same cycle.
- `gnt` and `done` are never high in the same cycle for the same requester.
- `rdata` is stable from the edge that asserts `done` until that requester's next read completes.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random requests → all outputs 0 and `mem_we` never 1. After release with both `req` high, `m0_gnt` is first.
- **Single read:** `data_mem` preloaded with word 4 = 0x0004. `m0` reads address 4 → `m0_gnt` at cycle +1, `m0_done` at +2 with `m0_rdata` = 0x0004, `m1_rdata` unchanged.
- **Write then read:** `m1` writes 0xBEEF to address 9, then `m0` reads address 9 → `mem_we` high exactly one cycle, `m0_rdata` = 0xBEEF.
- **Contention:** both requesters hold `req` for 12 cycles, reading addresses 7 and 4 (preloaded 0x0002 and 0x0004) → grant order 0,1,0,1. `m0_rdata` = 0x0002, `m1_rdata` = 0x0004. No cycle has both `gnt` or both `done` high.
- **Payload change after grant:** change `m0_addr` and `m0_wdata` in the ACCESS cycle → the write lands at the originally captured address with the originally captured data.
- **Reset during ACCESS:** assert `rst` in the ACCESS cycle of a write of 0x1234 to address 3 → address 3 keeps its old value, no `done`, FSM is in IDLE next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter_if : requester req/done bundles plus data_mem port   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master = requesters plus the memory; slave = the arbiter itself
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter : round-robin two-requester sequencer for data_mem   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic winner;
  logic in_access;
  logic in_resp;

  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign winner = bus.m1_req & (~bus.m0_req | ~last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.m0_req | bus.m1_req) begin
          owner_d     = winner;
          last_d      = winner;
          cmd_we_d    = winner ? bus.m1_we    : bus.m0_we;
          cmd_addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
          cmd_wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!cmd_we_q) begin
          if (owner_q) begin
            rdata1_d = bus.mem_rdata;
          end else begin
            rdata0_d = bus.mem_rdata;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  // Gating by rst keeps a write caught by reset from landing in memory.
  assign bus.mem_we    = in_access & cmd_we_q & ~rst;
  assign bus.mem_addr  = in_access ? cmd_addr_q  : '0;
  assign bus.mem_wdata = in_access ? cmd_wdata_q : '0;

  assign bus.m0_gnt   = in_access & ~owner_q;
  assign bus.m1_gnt   = in_access &  owner_q;
  assign bus.m0_done  = in_resp   & ~owner_q;
  assign bus.m1_done  = in_resp   &  owner_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_arbiter : self-checking bench for dmem_arbiter            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic load_en = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data_mem model: 256 words, combinational read, write on rising edge
  logic [DW-1:0] dmem [0:255];

  function automatic logic [DW-1:0] preload_val(input int i);
    return (i == 7) ? 16'h0002 : 16'(i);
  endfunction

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) dmem[i] <= preload_val(i);
    end else if (bus.mem_we) begin
      dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = dmem[bus.mem_addr[7:0]];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct {
    bit            port;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] mdl_rd [2];
  bit            mon_en = 1'b0;

  task automatic expect_done(input bit port, input bit we, input logic [DW-1:0] rd);
    exp_t e;
    if (!we) mdl_rd[port] = rd;
    e.port = port;
    e.rd0  = mdl_rd[0];
    e.rd1  = mdl_rd[1];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_both",    32'(bus.m0_gnt  & bus.m1_gnt),  32'd0);
      check("done_both",   32'(bus.m0_done & bus.m1_done), 32'd0);
      check("gnt_done_m0", 32'(bus.m0_gnt  & bus.m0_done), 32'd0);
      check("gnt_done_m1", 32'(bus.m1_gnt  & bus.m1_done), 32'd0);
      if (bus.m0_done || bus.m1_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_port", 32'(bus.m1_done), 32'(mon_e.port));
          check("m0_rdata",  32'(bus.m0_rdata), 32'(mon_e.rd0));
          check("m1_rdata",  32'(bus.m1_rdata), 32'(mon_e.rd1));
        end
      end
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},       32'({bus.m1_gnt, bus.m0_gnt}),   32'd0);
    check({tag, "_done"},      32'({bus.m1_done, bus.m0_done}), 32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_rdata"},     {bus.m1_rdata, bus.m0_rdata}, 32'd0);
  endtask

  // One isolated access, entered at a falling edge while the arbiter is idle.
  task automatic single(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    expect_done(port, we, rd);
    drive(port, 1'b1, we, addr, wd);
    @(posedge clk); #1;
    check("access_gnt",    32'({bus.m1_gnt, bus.m0_gnt}), port ? 32'd2 : 32'd1);
    check("access_addr",   32'(bus.mem_addr), 32'(addr));
    check("access_we",     32'(bus.mem_we),   32'(we));
    if (we) check("access_wdata", 32'(bus.mem_wdata), 32'(wd));
    @(posedge clk); #1;
    check("resp_done",     32'({bus.m1_done, bus.m0_done}), port ? 32'd2 : 32'd1);
    check("resp_mem_we",   32'(bus.mem_we), 32'd0);
    drive(port, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'd4,     16'h0000, 16'h0004};
    vecs[1] = '{1'b1, 1'b1, 16'd9,     16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'd9,     16'h0000, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 16'd7,     16'h0000, 16'h0002};
    vecs[4] = '{1'b0, 1'b1, 16'd20,    16'h5A5A, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'd20,    16'h0000, 16'h5A5A};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF,  16'h0000, 16'h00FF};
    vecs[7] = '{1'b1, 1'b1, 16'd0,     16'h0001, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 16'd0,     16'h0000, 16'h0001};
    vecs[9] = '{1'b0, 1'b0, 16'd4,     16'h0000, 16'h0004};

    mdl_rd[0] = '0;
    mdl_rd[1] = '0;

    // Reset held for two edges while requests toggle randomly
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      load_en = 1'b0;
      check_idle_outputs("reset");
    end

    // Contention straight out of reset: reads of 7 (m0) and 4 (m1) for 12 cycles
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'd7, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 16'd4, 16'h0000);
    expect_done(1'b0, 1'b0, 16'h0002);
    expect_done(1'b1, 1'b0, 16'h0004);
    expect_done(1'b0, 1'b0, 16'h0002);
    expect_done(1'b1, 1'b0, 16'h0004);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 0) begin
        check("contend_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), ((c / 3) % 2 == 1) ? 32'd2 : 32'd1);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
    end

    // Payload changed during ACCESS must not disturb the captured write
    expect_done(1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 16'd30, 16'h1111);
    @(posedge clk); #1;
    check("chg_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 16'd31, 16'h2222);
    #1;
    check("chg_mem_addr",  32'(bus.mem_addr),  32'd30);
    check("chg_mem_wdata", 32'(bus.mem_wdata), 32'h1111);
    @(posedge clk); #1;
    check("chg_done", 32'({bus.m1_done, bus.m0_done}), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("chg_mem30", 32'(dmem[30]), 32'h1111);
    check("chg_mem31", 32'(dmem[31]), 32'd31);
    @(negedge clk);

    // Reset arriving in the ACCESS cycle of a write
    drive(1'b1, 1'b1, 1'b1, 16'd3, 16'h1234);
    @(posedge clk); #1;
    check("rst_acc_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd2);
    check("rst_acc_we",  32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_gated_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    check_idle_outputs("rst_acc");
    @(negedge clk);
    rst = 1'b0;
    check("rst_mem3", 32'(dmem[3]), 32'd3);
    single(1'b1, 1'b0, 16'd3, 16'h0000, 16'h0003);

    // Tie after reset goes to requester 0 again
    drive(1'b0, 1'b1, 1'b0, 16'd4, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 16'd7, 16'h0000);
    expect_done(1'b0, 1'b0, 16'h0004);
    @(posedge clk); #1;
    check("tie_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd1);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
